// File: rtl/cpu_design_params.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : cpu_design_params                                               |
// | Brief    : Shared core sizing constants and types (ROB, rename, commit).   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package cpu_design_params;

    localparam int NUM_A_REGS = 32;
    localparam int ROB_SIZE   = 16;
    localparam int NUM_P_REGS = 48;

    typedef logic [31:0]                     pc_t;
    typedef logic [$clog2(NUM_P_REGS)-1:0]   prn_t;
    typedef logic [$clog2(NUM_A_REGS)-1:0]   arn_t;
    typedef logic [$clog2(ROB_SIZE)-1:0]     rob_idx_t;
    typedef logic [$clog2(ROB_SIZE)-1:0]     hist_ptr_t;

    typedef arn_t rrat_idx_t;

    typedef struct packed {
        logic      valid;
        logic      done;
        logic      exception;
        logic      writes_rd;
        arn_t      rd_arch;
        prn_t      p_new;
        prn_t      p_old;
        pc_t       pc;
        hist_ptr_t hist_ptr;
    } rob_data_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_RESTORE = 2'd2
    } commit_state_t;

endpackage

`default_nettype wire

// File: rtl/retire_rat.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : retire_rat                                                      |
// | Brief    : Retirement RAT, identity reset, 1 sync write, 1 comb read.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module retire_rat
    import cpu_design_params::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      we,
    input  rrat_idx_t waddr,
    input  prn_t      wdata,
    input  rrat_idx_t raddr,
    output prn_t      rdata
);

    prn_t r_map [NUM_A_REGS];

    generate
        for (genvar gi = 0; gi < NUM_A_REGS; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_map[gi] <= prn_t'(gi);
                end else if (we && (waddr == rrat_idx_t'(gi))) begin
                    r_map[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = r_map[raddr];

endmodule

`default_nettype wire

// File: rtl/commit_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : commit_unit                                                     |
// | Brief    : In-order retire, RRAT update, free-list push, flush + restore.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module commit_unit
    import cpu_design_params::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rob_head_valid,
    input  rob_data_t rob_head,
    output logic      rob_pop,
    output logic      fl_push_valid,
    output prn_t      fl_push_prn,
    input  logic      fl_push_ready,
    output logic      flush,
    output pc_t       flush_pc,
    output hist_ptr_t flush_hist_ptr,
    output logic      rat_restore_valid,
    output arn_t      rat_restore_arch,
    output prn_t      rat_restore_prn,
    output logic      restore_done
);

    localparam logic [1:0] c_ST_RUN     = ST_RUN;
    localparam logic [1:0] c_ST_FLUSH   = ST_FLUSH;
    localparam logic [1:0] c_ST_RESTORE = ST_RESTORE;
    localparam arn_t       c_LAST_IDX   = arn_t'(NUM_A_REGS - 1);

    logic [1:0] r_state;
    rrat_idx_t  r_idx;
    pc_t        r_flush_pc;
    hist_ptr_t  r_flush_hist_ptr;
    logic       r_restore_done;

    logic       w_run;
    logic       w_head_done;
    logic       w_exc;
    logic       w_retire;
    logic       w_rrat_we;
    prn_t       w_rrat_rdata;

    assign w_run       = (r_state == c_ST_RUN);
    assign w_head_done = rob_head_valid & rob_head.valid & rob_head.done;
    // Exception wins over writes_rd / fl_push_ready: the faulting entry never retires.
    assign w_exc       = w_run & w_head_done & rob_head.exception;
    assign w_retire    = w_run & w_head_done & ~rob_head.exception &
                         (~rob_head.writes_rd | fl_push_ready);
    assign w_rrat_we   = w_retire & rob_head.writes_rd;

    retire_rat u_retire_rat (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_rrat_we),
        .waddr (rob_head.rd_arch),
        .wdata (rob_head.p_new),
        .raddr (r_idx),
        .rdata (w_rrat_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= c_ST_RUN;
            r_idx            <= '0;
            r_flush_pc       <= '0;
            r_flush_hist_ptr <= '0;
            r_restore_done   <= 1'b0;
        end else begin
            r_restore_done <= 1'b0;
            case (r_state)
                c_ST_RUN: begin
                    if (w_exc) begin
                        r_flush_pc       <= rob_head.pc;
                        r_flush_hist_ptr <= rob_head.hist_ptr;
                        r_state          <= c_ST_FLUSH;
                    end
                end
                c_ST_FLUSH: begin
                    r_idx   <= '0;
                    r_state <= c_ST_RESTORE;
                end
                c_ST_RESTORE: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == c_LAST_IDX) begin
                        r_state        <= c_ST_RUN;
                        r_restore_done <= 1'b1;
                    end
                end
                default: r_state <= c_ST_RUN;
            endcase
        end
    end

    assign rob_pop           = w_retire;
    assign fl_push_valid     = w_rrat_we;
    assign fl_push_prn       = w_rrat_we ? rob_head.p_old : '0;
    assign flush             = (r_state == c_ST_FLUSH);
    assign flush_pc          = r_flush_pc;
    assign flush_hist_ptr    = r_flush_hist_ptr;
    assign rat_restore_valid = (r_state == c_ST_RESTORE);
    assign rat_restore_arch  = rat_restore_valid ? r_idx : '0;
    assign rat_restore_prn   = rat_restore_valid ? w_rrat_rdata : '0;
    assign restore_done      = r_restore_done;

endmodule

`default_nettype wire

// File: tb/tb_commit_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_commit_unit                                                  |
// | Brief    : Directed bench with a cycle-count reference model of commit.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_commit_unit;
    import cpu_design_params::*;

    logic      clk;
    logic      rst_n;
    logic      rob_head_valid;
    rob_data_t rob_head;
    logic      rob_pop;
    logic      fl_push_valid;
    prn_t      fl_push_prn;
    logic      fl_push_ready;
    logic      flush;
    pc_t       flush_pc;
    hist_ptr_t flush_hist_ptr;
    logic      rat_restore_valid;
    arn_t      rat_restore_arch;
    prn_t      rat_restore_prn;
    logic      restore_done;

    commit_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rob_head_valid    (rob_head_valid),
        .rob_head          (rob_head),
        .rob_pop           (rob_pop),
        .fl_push_valid     (fl_push_valid),
        .fl_push_prn       (fl_push_prn),
        .fl_push_ready     (fl_push_ready),
        .flush             (flush),
        .flush_pc          (flush_pc),
        .flush_hist_ptr    (flush_hist_ptr),
        .rat_restore_valid (rat_restore_valid),
        .rat_restore_arch  (rat_restore_arch),
        .rat_restore_prn   (rat_restore_prn),
        .restore_done      (restore_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_k counts cycles since the exception was seen
    // (0 = running, 1 = flush, 2..33 = restore beat m_k-2).
    int   m_rrat [NUM_A_REGS];
    int   m_k;
    logic m_done;
    int   m_pc;
    int   m_hist;

    function automatic logic head_done();
        return rob_head_valid && rob_head.valid && rob_head.done;
    endfunction

    function automatic logic exp_pop();
        return (m_k == 0) && head_done() && !rob_head.exception &&
               (!rob_head.writes_rd || fl_push_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_A_REGS; i++) m_rrat[i] <= i;
            m_k    <= 0;
            m_done <= 1'b0;
            m_pc   <= 0;
            m_hist <= 0;
        end else begin
            m_done <= (m_k == NUM_A_REGS + 1);
            if (m_k == NUM_A_REGS + 1) begin
                m_k <= 0;
            end else if (m_k > 0) begin
                m_k <= m_k + 1;
            end else if (head_done() && rob_head.exception) begin
                m_k    <= 1;
                m_pc   <= int'(rob_head.pc);
                m_hist <= int'(rob_head.hist_ptr);
            end else if (exp_pop() && rob_head.writes_rd) begin
                m_rrat[rob_head.rd_arch] <= int'(rob_head.p_new);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("rob_pop", 64'(rob_pop), 64'(exp_pop()));
            check("fl_push_valid", 64'(fl_push_valid), 64'(exp_pop() && rob_head.writes_rd));
            if (exp_pop() && rob_head.writes_rd)
                check("fl_push_prn", 64'(fl_push_prn), 64'(rob_head.p_old));
            check("flush", 64'(flush), 64'(m_k == 1));
            check("flush_pc", 64'(flush_pc), 64'(m_pc));
            check("flush_hist_ptr", 64'(flush_hist_ptr), 64'(m_hist));
            check("rat_restore_valid", 64'(rat_restore_valid), 64'(m_k >= 2));
            if (m_k >= 2) begin
                check("rat_restore_arch", 64'(rat_restore_arch), 64'(m_k - 2));
                check("rat_restore_prn", 64'(rat_restore_prn), 64'(m_rrat[m_k - 2]));
            end
            check("restore_done", 64'(restore_done), 64'(m_done));
        end
    end

    function automatic rob_data_t mk(input logic exc, input logic wr, input int rd,
                                     input int pnew, input int pold, input int pc,
                                     input int hist);
        rob_data_t d;
        d.valid     = 1'b1;
        d.done      = 1'b1;
        d.exception = exc;
        d.writes_rd = wr;
        d.rd_arch   = arn_t'(rd);
        d.p_new     = prn_t'(pnew);
        d.p_old     = prn_t'(pold);
        d.pc        = pc_t'(pc);
        d.hist_ptr  = hist_ptr_t'(hist);
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_head();
        rob_head_valid = 1'b0;
        rob_head       = '0;
    endtask

    // Raises an exception at the head and walks the full flush/restore sequence,
    // pinning one restored mapping with a literal.
    task automatic flush_and_restore(input int pc, input int hist, input int arch, input int prn);
        rob_head_valid = 1'b1;
        rob_head       = mk(1'b1, 1'b1, 9, 20, 21, pc, hist);
        @(negedge clk);
        check("exc_no_pop", 64'(rob_pop), 64'd0);
        check("exc_no_push", 64'(fl_push_valid), 64'd0);
        step();
        idle_head();
        @(negedge clk);
        check("lit_flush", 64'(flush), 64'd1);
        check("lit_flush_pc", 64'(flush_pc), 64'(pc));
        check("lit_flush_hist", 64'(flush_hist_ptr), 64'(hist));
        for (int b = 0; b < NUM_A_REGS; b++) begin
            step();
            @(negedge clk);
            if (b == arch) check("lit_restore_prn", 64'(rat_restore_prn), 64'(prn));
        end
        step();
        @(negedge clk);
        check("lit_restore_done", 64'(restore_done), 64'd1);
        step();
    endtask

    initial begin
        rst_n         = 1'b0;
        fl_push_ready = 1'b1;
        idle_head();
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) step();
        check("lit_reset_pop", 64'(rob_pop), 64'd0);
        check("lit_reset_flush_pc", 64'(flush_pc), 64'd0);
        rst_n = 1'b1;
        repeat (40) step();

        // Identity restore after reset.
        flush_and_restore(32'h2000, 3, 17, 17);

        // Simple retire arch 5 -> 40.
        rob_head_valid = 1'b1;
        rob_head       = mk(1'b0, 1'b1, 5, 40, 5, 32'h100, 0);
        @(negedge clk);
        check("lit_pop", 64'(rob_pop), 64'd1);
        check("lit_push_prn", 64'(fl_push_prn), 64'd5);
        step();
        idle_head();
        step();
        flush_and_restore(32'h3000, 1, 5, 40);

        // Free-list backpressure for 3 cycles.
        rob_head_valid = 1'b1;
        rob_head       = mk(1'b0, 1'b1, 6, 41, 6, 32'h104, 0);
        fl_push_ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lit_stall_pop", 64'(rob_pop), 64'd0);
            check("lit_stall_push", 64'(fl_push_valid), 64'd0);
            step();
        end
        fl_push_ready = 1'b1;
        @(negedge clk);
        check("lit_unstall_pop", 64'(rob_pop), 64'd1);
        step();
        idle_head();
        step();

        // Exception with writes_rd set.
        flush_and_restore(32'h1000, 7, 6, 41);

        // Reset during restore beat 10.
        rob_head_valid = 1'b1;
        rob_head       = mk(1'b1, 1'b0, 0, 0, 0, 32'h5000, 4);
        step();
        idle_head();
        repeat (11) step();
        check("lit_beat10_arch", 64'(rat_restore_arch), 64'd10);
        rst_n = 1'b0;
        #1;
        check("lit_rst_restore_valid", 64'(rat_restore_valid), 64'd0);
        check("lit_rst_flush_pc", 64'(flush_pc), 64'd0);
        check("lit_rst_hist", 64'(flush_hist_ptr), 64'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        flush_and_restore(32'h4000, 2, 5, 5);

        // Back-to-back retires to arch 3.
        rob_head_valid = 1'b1;
        rob_head       = mk(1'b0, 1'b1, 3, 33, 3, 32'h200, 0);
        @(negedge clk);
        check("lit_b2b_push0", 64'(fl_push_prn), 64'd3);
        step();
        rob_head       = mk(1'b0, 1'b1, 3, 44, 33, 32'h204, 0);
        @(negedge clk);
        check("lit_b2b_push1", 64'(fl_push_prn), 64'd33);
        step();
        idle_head();
        step();
        flush_and_restore(32'h6000, 5, 3, 44);

        repeat (3) step();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/commit_unit.md
# commit_unit

In-order retirement stage of the out-of-order core. It sits between the ROB head and the rename unit. Each cycle it retires at most one completed ROB entry, updates the retirement RAT (RRAT), and pushes the superseded physical register (`p_old`) back to the free list; this is the push side of the free list that rename pops. When an excepting instruction reaches the head, it raises a one-cycle flush, then streams the RRAT back to the front-end RAT so rename can resume from precise architectural state.

## Interface
Parameters (from `cpu_design_params`):
- `NUM_A_REGS`, default 32: architectural registers; RRAT depth and restore length.
- `ROB_SIZE`, default 16: sets `rob_idx_t` and `hist_ptr_t`.
- `NUM_P_REGS`, default 48: physical registers; sets `prn_t` width.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rob_head_valid`  in  1  ROB non-empty; `rob_head` is meaningful.
- `rob_head`  in  `rob_data_t`  oldest ROB entry.
- `rob_pop`  out  1  retire the head this cycle; ROB advances at the edge.
- `fl_push_valid`  out  1  free-list push strobe.
- `fl_push_prn`  out  `prn_t`  register returned to the free list.
- `fl_push_ready`  in  1  free list can accept a push.
- `flush`  out  1  one-cycle pipeline squash pulse.
- `flush_pc`  out  `pc_t`  PC of the excepting instruction.
- `flush_hist_ptr`  out  `hist_ptr_t`  rename-history pointer for rename/free-list rollback.
- `rat_restore_valid`  out  1  restore beat valid.
- `rat_restore_arch`  out  `arn_t`  architectural index being restored.
- `rat_restore_prn`  out  `prn_t`  committed mapping for that index.
- `restore_done`  out  1  one-cycle pulse after the final restore beat.

## Operation
- FSM states: RUN, FLUSH, RESTORE. Reset state is RUN.
- RRAT: `NUM_A_REGS` entries of `prn_t`. Reset value is the identity mapping, entry i = i.
- Retire condition in RUN: `retire_ok = rob_head_valid & rob_head.valid & rob_head.done & ~rob_head.exception & (~rob_head.writes_rd | fl_push_ready)`.
  - `rob_pop = retire_ok`.
  - `fl_push_valid = retire_ok & writes_rd`.
  - `fl_push_prn = rob_head.p_old`.
  - At the edge, if retiring with `writes_rd`, the RRAT is written: `RRAT[rd_arch] <= p_new`.
- Free-list backpressure: with `writes_rd=1` and `fl_push_ready=0`, the unit stalls. `rob_pop` stays 0 and the RRAT is not written.
- Exception: in RUN, if `rob_head_valid & valid & done & exception`:
  - Capture `pc` and `hist_ptr` into the `flush_pc`/`flush_hist_ptr` registers and go to FLUSH.
  - The excepting entry is never retired: no pop, no push, no RRAT write.
  - Exception takes priority over `writes_rd` and over `fl_push_ready`.
- FLUSH (1 cycle): `flush=1`, then go to RESTORE with the restore index cleared.
- RESTORE (`NUM_A_REGS` cycles):
  - Each cycle: `rat_restore_valid=1`, `rat_restore_arch=idx`, `rat_restore_prn=RRAT[idx]`, and `idx` increments.
  - On the beat with idx = `NUM_A_REGS-1`, go to RUN.
  - `restore_done` is a registered pulse in the first RUN cycle after the last beat.
- In FLUSH and RESTORE, `rob_pop`, `fl_push_valid` and RRAT writes are 0, and the ROB head is ignored.
- Reset, including mid-RESTORE:
  - State returns to RUN and the RRAT to identity.
  - All outputs 0, including `flush_pc` and `flush_hist_ptr`.

## Timing
- Retire decision is combinational from head and ready: zero-cycle latency from head done to `rob_pop`.
- RRAT update is visible to a restore read in the next cycle.
- Exception at head in cycle N:
  - `flush=1` in N+1.
  - Restore beats N+2 … N+33 (32 beats).
  - `restore_done` in N+34.
  - First possible retire is also N+34.
- Throughput is one retire per cycle. Back-to-back retires to the same `rd_arch` apply in order: the last write wins.
- `fl_push_valid` is never asserted while `fl_push_ready=0`.

## Structure
- Add to `cpu_design_params`:
  - `commit_state_t` enum (RUN/FLUSH/RESTORE).
  - `rrat_idx_t` as an alias of `arn_t`.
- Reuse `rob_data_t`, `prn_t`, `arn_t`, `pc_t` and `hist_ptr_t` unchanged.
- One sub-module, `retire_rat`, holds the RRAT:
  - Identity reset.
  - One synchronous write port.
  - One combinational read port for the restore stream.

## Test plan
- Reset, then idle for 40 cycles. Expect all outputs 0 and `rob_pop=0`. Then force an exception: restore beats must give prn = arch for 0..31.
- Retire head {done, writes_rd, rd_arch=5, p_new=40, p_old=5} with ready=1. Expect `rob_pop=1` and push of 5 in the same cycle. A later flush restores arch 5 → 40.
- Same entry with `fl_push_ready=0` for 3 cycles. Expect no pop and no push for 3 cycles; retire in the cycle ready rises.
- Head {done, exception, pc=0x1000, hist_ptr=7, writes_rd}. Expect no pop and no push; `flush` one cycle later with `flush_pc=0x1000` and `flush_hist_ptr=7`; 32 restore beats; `restore_done` after the last beat.
- Assert `rst_n` low during restore beat 10. Expect immediate RUN state, outputs 0, and RRAT back to identity.
- Retire to arch 3 with p_new=33, then arch 3 with p_new=44 back-to-back. Expect pushes of the respective p_old values; the restore shows 3 → 44.
